block_mem_arbiter: RTL and testbench

//  Shared responder for the instruction-cache and data-cache block-memory ports; initiator toward one unified block memory.
//  - Accepts 128-bit block reads from the icache and block reads/writes from the dcache.
//  - Serialises them onto a single memory port, using round-robin arbitration.
//  - Returns data and busywait to each cache with the same busywait handshake the caches already use toward their memories.

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/block_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_block_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-unified-memory block interface:
// arbiter FSM encoding, grant identifiers and default bus widths.
package mem_if_pkg;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_BLOCK_W = 128;
  localparam int TCNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; remembers the side that completed last
// and favours the other one when both request together.
module rr_arbiter2
  import mem_if_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  input  logic upd_gnt,
  output logic gnt_valid,
  output logic gnt_sel
);

  logic last_gnt;

  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt_sel = ~last_gnt;
    end else if (req_d) begin
      gnt_sel = GNT_D;
    end else begin
      gnt_sel = GNT_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_I;
    end else if (update) begin
      last_gnt <= upd_gnt;
    end
  end

endmodule

// File: rtl/block_mem_arbiter.sv
// Serialises icache block reads and dcache block reads/writes onto one unified
// block memory, answering each cache with its usual busywait handshake.
module block_mem_arbiter
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IMEM_READ,
  input  logic [ADDR_W-1:0]  IMEM_ADDRESS,
  output logic [BLOCK_W-1:0] IMEM_READDATA,
  output logic               IMEM_BUSYWAIT,
  input  logic               MEM_READ,
  input  logic               MEM_WRITE,
  input  logic [ADDR_W-1:0]  MEM_ADDRESS,
  input  logic [BLOCK_W-1:0] MEM_WRITEDATA,
  output logic [BLOCK_W-1:0] MEM_READDATA,
  output logic               MEM_BUSYWAIT,
  output logic               U_READ,
  output logic               U_WRITE,
  output logic [ADDR_W-1:0]  U_ADDRESS,
  output logic [BLOCK_W-1:0] U_WRITEDATA,
  input  logic [BLOCK_W-1:0] U_READDATA,
  input  logic               U_BUSYWAIT,
  output logic               ERROR
);

  localparam logic [TCNT_W-1:0] TIMEOUT_CNT = TCNT_W'(TIMEOUT);

  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  arb_state_e        state;
  logic              gnt;
  logic              done_i;
  logic              done_d;
  logic              seen_busy;
  logic [TCNT_W-1:0] tcnt;

  logic              req_d;
  logic              gnt_valid;
  logic              gnt_sel;
  logic [TCNT_W-1:0] tcnt_nxt;
  logic              mem_ok;
  logic              tmo_hit;
  logic              finish;

  assign req_d    = MEM_READ | MEM_WRITE;
  assign tcnt_nxt = sat_inc(tcnt);
  // A real completion needs the memory to have gone busy first, so a slow
  // memory that has not yet raised busywait is not mistaken for done.
  assign mem_ok   = (state == ST_WAIT) && seen_busy && !U_BUSYWAIT;
  assign tmo_hit  = (state == ST_WAIT) && !mem_ok && (tcnt_nxt == TIMEOUT_CNT);
  assign finish   = mem_ok | tmo_hit;

  always_comb begin
    IMEM_BUSYWAIT = 1'b0;
    MEM_BUSYWAIT  = 1'b0;
    if (!RESET) begin
      IMEM_BUSYWAIT = IMEM_READ & ~done_i;
      MEM_BUSYWAIT  = req_d & ~done_d;
    end
  end

  rr_arbiter2 u_rr (
    .clk       (CLK),
    .rst       (RESET),
    .req_i     (IMEM_READ),
    .req_d     (req_d),
    .update    (finish),
    .upd_gnt   (gnt),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      gnt           <= GNT_I;
      U_READ        <= 1'b0;
      U_WRITE       <= 1'b0;
      U_ADDRESS     <= '0;
      U_WRITEDATA   <= '0;
      IMEM_READDATA <= '0;
      MEM_READDATA  <= '0;
      ERROR         <= 1'b0;
      done_i        <= 1'b0;
      done_d        <= 1'b0;
      seen_busy     <= 1'b0;
      tcnt          <= '0;
    end else begin
      done_i <= 1'b0;
      done_d <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt   <= gnt_sel;
            state <= ST_ISSUE;
            if (gnt_sel == GNT_D) begin
              U_ADDRESS   <= MEM_ADDRESS;
              U_WRITEDATA <= MEM_WRITEDATA;
              U_READ      <= MEM_READ;
              U_WRITE     <= MEM_WRITE;
            end else begin
              U_ADDRESS <= IMEM_ADDRESS;
              U_READ    <= 1'b1;
              U_WRITE   <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          seen_busy <= 1'b0;
          tcnt      <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          tcnt <= tcnt_nxt;
          if (U_BUSYWAIT) begin
            seen_busy <= 1'b1;
          end
          if (mem_ok && U_READ) begin
            if (gnt == GNT_D) begin
              MEM_READDATA <= U_READDATA;
            end else begin
              IMEM_READDATA <= U_READDATA;
            end
          end
          if (tmo_hit) begin
            ERROR <= 1'b1;
          end
          // Timeout also releases the requester; its READDATA is left untouched.
          if (finish) begin
            U_READ  <= 1'b0;
            U_WRITE <= 1'b0;
            done_i  <= (gnt == GNT_I);
            done_d  <= (gnt == GNT_D);
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Directed bench for block_mem_arbiter with a behavioural unified memory and
// an issue-order scoreboard.
module tb_block_mem_arbiter;
  import mem_if_pkg::*;

  localparam int BUDGET = 400;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         IMEM_READ;
  logic [27:0]  IMEM_ADDRESS;
  logic [127:0] IMEM_READDATA;
  logic         IMEM_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic         U_READ;
  logic         U_WRITE;
  logic [27:0]  U_ADDRESS;
  logic [127:0] U_WRITEDATA;
  logic [127:0] U_READDATA;
  logic         U_BUSYWAIT;
  logic         ERROR;

  block_mem_arbiter #(.ADDR_W(28), .BLOCK_W(128), .TIMEOUT(255)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .U_READ        (U_READ),
    .U_WRITE       (U_WRITE),
    .U_ADDRESS     (U_ADDRESS),
    .U_WRITEDATA   (U_WRITEDATA),
    .U_READDATA    (U_READDATA),
    .U_BUSYWAIT    (U_BUSYWAIT),
    .ERROR         (ERROR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] def_data(input logic [27:0] a);
    return {4{4'h0, a}};
  endfunction

  // Unified memory: samples a strobe on posedge, stays busy for busy_cycles
  // sampled cycles, then waits for the strobe to drop before accepting again.
  int           busy_cycles = 2;
  int           mcnt;
  logic         mactive = 1'b0;
  logic         mhold = 1'b0;
  logic         mop_rd;
  logic [27:0]  maddr;
  logic [127:0] mem_data [logic [27:0]];

  always @(posedge CLK) begin
    if (RESET) begin
      mactive    <= 1'b0;
      mhold      <= 1'b0;
      U_BUSYWAIT <= 1'b0;
    end else if (mactive) begin
      if (mcnt <= 1) begin
        U_BUSYWAIT <= 1'b0;
        mactive    <= 1'b0;
        mhold      <= 1'b1;
        if (mop_rd) begin
          U_READDATA <= mem_data.exists(maddr) ? mem_data[maddr] : def_data(maddr);
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end else if (mhold) begin
      if (!(U_READ || U_WRITE)) mhold <= 1'b0;
    end else if (U_READ || U_WRITE) begin
      mactive    <= 1'b1;
      U_BUSYWAIT <= 1'b1;
      mcnt       <= busy_cycles;
      mop_rd     <= U_READ;
      maddr      <= U_ADDRESS;
      if (U_WRITE) mem_data[U_ADDRESS] = U_WRITEDATA;
    end
  end

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t mt;
  logic prev_stb = 1'b0;
  int   hi_len = 0;
  int   last_len = 0;

  // Scoreboard: each new strobe must match the next expected transaction.
  always @(negedge CLK) begin
    if ((U_READ || U_WRITE) && !prev_stb) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        mt = exp_q.pop_front();
        check("issue_read", U_READ, !mt.wr);
        check("issue_write", U_WRITE, mt.wr);
        check("issue_addr", U_ADDRESS, mt.addr);
        if (mt.wr) check("issue_wdata", U_WRITEDATA, mt.wdata);
      end
    end
    if (U_READ || U_WRITE) begin
      hi_len++;
    end else if (prev_stb) begin
      last_len = hi_len;
      hi_len   = 0;
    end
    prev_stb = U_READ || U_WRITE;
  end

  task automatic push(input logic wr, input logic [27:0] a, input logic [127:0] wd);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd;
    exp_q.push_back(t);
  endtask

  task automatic wait_i(input logic [127:0] exp, input string tag);
    bit done = 0;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge CLK);
      if (!IMEM_BUSYWAIT) done = 1;
    end
    if (done) check({tag, "_data"}, IMEM_READDATA, exp);
    else check({tag, "_expired"}, 0, 1);
    IMEM_READ = 1'b0;
  endtask

  task automatic icache_read(input logic [27:0] a, input logic [127:0] exp, input string tag);
    IMEM_ADDRESS = a;
    IMEM_READ    = 1'b1;
    wait_i(exp, tag);
  endtask

  task automatic dcache_op(input logic wr, input logic [27:0] a, input logic [127:0] wd,
                           input logic [127:0] exp, input string tag);
    bit done = 0;
    MEM_ADDRESS   = a;
    MEM_WRITEDATA = wd;
    MEM_WRITE     = wr;
    MEM_READ      = !wr;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge CLK);
      if (!MEM_BUSYWAIT) done = 1;
    end
    if (!done) check({tag, "_expired"}, 0, 1);
    else if (!wr) check({tag, "_data"}, MEM_READDATA, exp);
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  localparam logic [127:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] W2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
  localparam logic [127:0] W3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    bit started;
    bit i_low;
    bit idle_seen;
    RESET = 1'b1; IMEM_READ = 1'b0; IMEM_ADDRESS = '0;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0; MEM_ADDRESS = '0; MEM_WRITEDATA = '0;
    U_READDATA = '0;
    mem_data[28'h0000004] = {16{8'hA5}};

    // Reset held with an icache request pending
    IMEM_ADDRESS = 28'h0000004;
    IMEM_READ    = 1'b1;
    busy_cycles  = 5;
    push(1'b0, 28'h0000004, '0);
    repeat (3) @(negedge CLK);
    check("rst_u_read", U_READ, 0);
    check("rst_u_write", U_WRITE, 0);
    check("rst_u_addr", U_ADDRESS, 0);
    check("rst_u_wdata", U_WRITEDATA, 0);
    check("rst_i_rdata", IMEM_READDATA, 0);
    check("rst_d_rdata", MEM_READDATA, 0);
    check("rst_error", ERROR, 0);
    check("rst_i_busy", IMEM_BUSYWAIT, 0);
    check("rst_d_busy", MEM_BUSYWAIT, 0);
    RESET = 1'b0;
    @(negedge CLK);
    check("grant_i_1cycle", U_READ, 1);
    check("i_busy_pending", IMEM_BUSYWAIT, 1);
    wait_i({16{8'hA5}}, "i_read_a5");
    @(negedge CLK);
    check("u_read_high_len", last_len, 7);

    // Simultaneous icache read and dcache write: dcache goes first
    busy_cycles = 2;
    push(1'b1, 28'h0000100, W1);
    push(1'b0, 28'h0000008, '0);
    fork
      dcache_op(1'b1, 28'h0000100, W1, '0, "d_write_first");
      icache_read(28'h0000008, def_data(28'h0000008), "i_after_d");
      begin
        started = 0; i_low = 0;
        for (int k = 0; k < BUDGET; k++) begin
          @(negedge CLK);
          if (U_WRITE) started = 1;
          if (started && !IMEM_BUSYWAIT) i_low = 1;
          if (started && !U_WRITE) break;
        end
        check("d_write_seen", started, 1);
        check("i_stall_during_d", i_low, 0);
      end
    join

    // Back-to-back contention: issue order must alternate D,I,D,I,...
    push(1'b1, 28'h0000200, W2); push(1'b0, 28'h0000010, '0);
    push(1'b0, 28'h0000200, '0); push(1'b0, 28'h0000014, '0);
    push(1'b1, 28'h0000300, W3); push(1'b0, 28'h0000018, '0);
    push(1'b0, 28'h0000300, '0); push(1'b0, 28'h000001C, '0);
    fork
      begin
        dcache_op(1'b1, 28'h0000200, W2, '0, "rr_d0");
        dcache_op(1'b0, 28'h0000200, '0, W2, "rr_d1");
        dcache_op(1'b1, 28'h0000300, W3, '0, "rr_d2");
        dcache_op(1'b0, 28'h0000300, '0, W3, "rr_d3");
      end
      begin
        icache_read(28'h0000010, def_data(28'h0000010), "rr_i0");
        icache_read(28'h0000014, def_data(28'h0000014), "rr_i1");
        icache_read(28'h0000018, def_data(28'h0000018), "rr_i2");
        icache_read(28'h000001C, def_data(28'h000001C), "rr_i3");
      end
    join
    check("rr_all_issued", exp_q.size(), 0);

    // Memory stuck busy: timeout raises ERROR and releases the dcache
    busy_cycles = 300;
    push(1'b0, 28'h0000400, '0);
    dcache_op(1'b0, 28'h0000400, '0, W3, "tmo_rdata_kept");
    check("tmo_error", ERROR, 1);
    @(negedge CLK);
    check("tmo_strobe_len", last_len, 256);
    check("tmo_state_idle", dut.state, ST_IDLE);
    idle_seen = 0;
    for (int k = 0; k < BUDGET && !idle_seen; k++) begin
      @(negedge CLK);
      if (!U_BUSYWAIT) idle_seen = 1;
    end
    check("tmo_mem_recovers", idle_seen, 1);
    check("tmo_error_sticky", ERROR, 1);

    // Reset pulsed in WAIT, then the same request re-issued
    busy_cycles = 10;
    push(1'b0, 28'h0000020, '0);
    IMEM_ADDRESS = 28'h0000020;
    IMEM_READ    = 1'b1;
    repeat (4) @(negedge CLK);
    check("pre_rst_in_wait", dut.state, ST_WAIT);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid_u_read", U_READ, 0);
    check("rst_mid_state", dut.state, ST_IDLE);
    check("rst_mid_i_busy", IMEM_BUSYWAIT, 0);
    check("rst_mid_error_clr", ERROR, 0);
    busy_cycles = 3;
    push(1'b0, 28'h0000020, '0);
    RESET = 1'b0;
    wait_i(def_data(28'h0000020), "reissue_after_rst");
    repeat (2) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
